systolic_conv_engine: RTL and testbench
=======================================

Name: systolic_conv_engine

Overview:
- Single-channel-in, NUM_CH-channel-out 2-D valid convolution engine (LeNet layer 1 style, default 28x28 image, 5x5 kernel, 6 output channels).
- Acts as master of an external synchronous image ROM (1-cycle read latency).
- Runs NUM_CH parallel MACs over each output window.
- Stores results in an internal result memory, readable through a combinational read port.

Parameters:
- INT_WIDTH, 8: pixel and weight width.
- ACC_WIDTH, 32: accumulator/result width (signed).
- NUM_CH, 6: output channels.
- MAX_K, 5: largest supported kernel size.
- ROM_ADDR_W, 10: image ROM address width.
- RES_DEPTH, 576: result entries per channel.
- RES_ADDR_W, 10: result address width.

Ports:
- clk_i  in  1  clock; everything rising-edge.
- rst_i  in  1  synchronous active-high reset.
- cfg_img_w_i  in  8  image width.
- cfg_img_h_i  in  8  image height.
- cfg_kernel_r_i  in  4  kernel size K (KxK).
- start_i  in  1  start pulse.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle completion pulse.
- rom_addr_o  out  ROM_ADDR_W  image ROM address.
- rom_rd_en_o  out  1  ROM read enable.
- rom_data_i  in  INT_WIDTH  ROM data, valid the cycle after rd_en.
- wt_we_i  in  1  weight write strobe.
- wt_ch_i  in  3  weight channel.
- wt_idx_i  in  5  weight tap index kr*K+kc.
- wt_data_i  in  INT_WIDTH  signed weight.
- res_ch_i  in  3  result read channel.
- res_addr_i  in  RES_ADDR_W  result read index.
- res_data_o  out  ACC_WIDTH  combinational read of result_mem[res_ch_i][res_addr_i].

Behaviour:
- Reset:
  - busy_o, done_o, rom_rd_en_o = 0; rom_addr_o = 0.
  - FSM to IDLE; accumulators cleared.
  - Weight and result memories are not cleared.
- Arithmetic:
  - Pixels are unsigned. Weights are signed.
  - Product = signed(zero-extended pixel) x weight, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- Output size: OUT_W = W-K+1, OUT_H = H-K+1.
- Output index: idx = r*OUT_W + c, raster order, row-major.
- IDLE:
  - start_i samples cfg into internal registers.
  - busy_o = 1 from the next cycle.
  - Config is ignored while busy.
  - start_i while busy is ignored.
- Invalid config (K=0, K>MAX_K, K>W, K>H, or OUT_W*OUT_H>RES_DEPTH):
  - go to DONE immediately; no ROM reads, no result writes.
  - done_o pulses the cycle after start_i.
- RUN, per output pixel (r,c):
  - Issue phase, K*K cycles: tap t=(kr,kc) in kr-major order.
  - Each issue cycle drives rom_rd_en_o=1 and rom_addr_o=(r+kr)*W+(c+kc).
  - One cycle after each issue, every channel ch accumulates pixel*weight[ch][t].
  - Drain/store cycle (1 cycle, rom_rd_en_o=0): the final product is added and each channel writes acc+product to result_mem[ch][idx]. Accumulators then clear.
  - Per pixel: K*K+1 cycles.
  - Total run: OUT_H*OUT_W*(K*K+1) cycles.
- DONE:
  - done_o = 1 for exactly one cycle, immediately after the last store.
  - busy_o drops in the same cycle; return to IDLE.
- Weights:
  - Writes accepted any time.
  - A write landing during a run takes effect on the next tap read; this case is undefined for verification.
- Reset mid-run: abort to IDLE next edge; partial results remain; done_o not asserted.
- Result read port: reflects a write on the cycle after it.

Optional Feature:
- Macro CONV_ENGINE_RELU_EN.
- Defined: the store value is max(0, acc) per channel; negatives are stored as 0.
- Undefined: the raw signed accumulator is stored.
- Timing is identical either way.

Test Plan:
- Reset:
  - Hold rst_i 3 cycles -> busy_o=0, done_o=0, rom_rd_en_o=0.
- Full LeNet run:
  - Setup: W=H=28, K=5; all pixels 1; weight ch0=1, ch5=-2, others 0.
  - Expect: result[ch0][0..575]=25, result[ch5][*]=-50 (0xFFFFFFCE).
  - Expect: done_o exactly 14976 cycles after busy_o rises.
- Address/order:
  - Setup: W=H=4, K=3; pixel[a]=a; ch0 centre tap (idx 4)=1, others 0.
  - Expect: result[0][0..3]=5,6,9,10.
  - Expect: first ROM addresses issued 0,1,2,4,5,6,8,9,10.
- Extremes:
  - Setup: W=H=1, K=1, pixel 255, weight -128.
  - Expect: result[0][0]=-32640; done_o 2 cycles after busy_o rises.
  - With RELU_EN: stored value 0.
- Invalid config:
  - K=0 -> done_o one cycle after start_i; rom_rd_en_o never 1; memories unchanged.
- Interference:
  - start_i again mid-run -> ignored; a single done_o occurs.
  - rst_i mid-run -> busy_o=0 next cycle; no done_o.

Source files
------------

// File: rtl/systolic_conv_engine.sv
// ============================================================================
// Module      : systolic_conv_engine
// Description : Single-input, NUM_CH-output 2-D valid convolution engine that
//               masters a 1-cycle-latency image ROM and keeps its results in an
//               internal per-channel memory. CONV_ENGINE_RELU_EN stores
//               max(0, acc) instead of the raw accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_conv_engine #(
    parameter int INT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_CH     = 6,
    parameter int MAX_K      = 5,
    parameter int ROM_ADDR_W = 10,
    parameter int RES_DEPTH  = 576,
    parameter int RES_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            cfg_img_w_i,
    input  logic [7:0]            cfg_img_h_i,
    input  logic [3:0]            cfg_kernel_r_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    output logic                  rom_rd_en_o,
    input  logic [INT_WIDTH-1:0]  rom_data_i,
    input  logic                  wt_we_i,
    input  logic [2:0]            wt_ch_i,
    input  logic [4:0]            wt_idx_i,
    input  logic [INT_WIDTH-1:0]  wt_data_i,
    input  logic [2:0]            res_ch_i,
    input  logic [RES_ADDR_W-1:0] res_addr_i,
    output logic [ACC_WIDTH-1:0]  res_data_o
);

    localparam int NUM_TAPS = MAX_K * MAX_K;
    localparam int PROD_W   = 2 * INT_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            img_w_q, img_w_d, out_w_q, out_w_d, out_h_q, out_h_d;
    logic [7:0]            r_q, r_d, c_q, c_d;
    logic [3:0]            k_q, k_d, kr_q, kr_d, kc_q, kc_d;
    logic [4:0]            kk_q, kk_d, tap_q, tap_d, prev_tap_q, prev_tap_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [RES_ADDR_W-1:0] idx_q, idx_d;

    logic                  issue, drain, cfg_ok;
    logic [7:0]            cfg_out_w, cfg_out_h;
    logic [15:0]           cfg_area;
    logic [ACC_WIDTH-1:0]  ch_rd [NUM_CH];

    assign issue = (state_q == S_RUN) && (tap_q != kk_q);
    assign drain = (state_q == S_RUN) && (tap_q == kk_q);

    always_comb begin
        cfg_out_w = cfg_img_w_i - {4'd0, cfg_kernel_r_i} + 8'd1;
        cfg_out_h = cfg_img_h_i - {4'd0, cfg_kernel_r_i} + 8'd1;
        cfg_area  = 16'(cfg_out_w) * 16'(cfg_out_h);
        cfg_ok    = (cfg_kernel_r_i != 4'd0)
                 && (32'(cfg_kernel_r_i) <= 32'(MAX_K))
                 && ({4'd0, cfg_kernel_r_i} <= cfg_img_w_i)
                 && ({4'd0, cfg_kernel_r_i} <= cfg_img_h_i)
                 && (32'(cfg_area) <= 32'(RES_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        img_w_d    = img_w_q;
        out_w_d    = out_w_q;
        out_h_d    = out_h_q;
        k_d        = k_q;
        kk_d       = kk_q;
        r_d        = r_q;
        c_d        = c_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        tap_d      = tap_q;
        idx_d      = idx_q;
        prev_vld_d = issue;
        prev_tap_d = tap_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    img_w_d = cfg_img_w_i;
                    out_w_d = cfg_out_w;
                    out_h_d = cfg_out_h;
                    k_d     = cfg_kernel_r_i;
                    kk_d    = 5'(cfg_kernel_r_i) * 5'(cfg_kernel_r_i);
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                    kr_d    = 4'd0;
                    kc_d    = 4'd0;
                    tap_d   = 5'd0;
                    idx_d   = '0;
                    state_d = cfg_ok ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (issue) begin
                    tap_d = tap_q + 5'd1;
                    if (kc_q == k_q - 4'd1) begin
                        kc_d = 4'd0;
                        kr_d = kr_q + 4'd1;
                    end else begin
                        kc_d = kc_q + 4'd1;
                    end
                end else begin
                    // Drain cycle: window finished, step to the next output pixel.
                    tap_d = 5'd0;
                    kr_d  = 4'd0;
                    kc_d  = 4'd0;
                    idx_d = idx_q + RES_ADDR_W'(1);
                    if (c_q == out_w_q - 8'd1) begin
                        c_d = 8'd0;
                        r_d = r_q + 8'd1;
                        if (r_q == out_h_q - 8'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            img_w_q    <= 8'd0;
            out_w_q    <= 8'd0;
            out_h_q    <= 8'd0;
            k_q        <= 4'd0;
            kk_q       <= 5'd0;
            r_q        <= 8'd0;
            c_q        <= 8'd0;
            kr_q       <= 4'd0;
            kc_q       <= 4'd0;
            tap_q      <= 5'd0;
            idx_q      <= '0;
            prev_vld_q <= 1'b0;
            prev_tap_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            img_w_q    <= img_w_d;
            out_w_q    <= out_w_d;
            out_h_q    <= out_h_d;
            k_q        <= k_d;
            kk_q       <= kk_d;
            r_q        <= r_d;
            c_q        <= c_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            tap_q      <= tap_d;
            idx_q      <= idx_d;
            prev_vld_q <= prev_vld_d;
            prev_tap_q <= prev_tap_d;
        end
    end

    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign rom_rd_en_o = issue;
    assign rom_addr_o  = issue ? (ROM_ADDR_W'(r_q) + ROM_ADDR_W'(kr_q)) * ROM_ADDR_W'(img_w_q)
                                 + ROM_ADDR_W'(c_q) + ROM_ADDR_W'(kc_q)
                               : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mac
        logic signed [INT_WIDTH-1:0] wt_mem_q [NUM_TAPS];
        logic        [ACC_WIDTH-1:0] res_mem_q [RES_DEPTH];
        logic signed [INT_WIDTH-1:0] wt;
        logic signed [PROD_W-1:0]    pix_ext, wt_ext, prod;
        logic        [ACC_WIDTH-1:0] acc_q, acc_d, sum, store_val;

        // ROM data lands one cycle after its issue, so it pairs with the previous tap.
        always_comb begin
            wt      = wt_mem_q[prev_tap_q];
            pix_ext = {{(INT_WIDTH + 1){1'b0}}, rom_data_i};
            wt_ext  = {{(INT_WIDTH + 1){wt[INT_WIDTH-1]}}, wt};
            prod    = pix_ext * wt_ext;
            sum     = acc_q + (prev_vld_q ? {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod} : '0);
            acc_d   = drain ? '0 : sum;
`ifdef CONV_ENGINE_RELU_EN
            store_val = sum[ACC_WIDTH-1] ? '0 : sum;
`else
            store_val = sum;
`endif
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (wt_we_i && (32'(wt_ch_i) == g) && (32'(wt_idx_i) < 32'(NUM_TAPS))) begin
                wt_mem_q[wt_idx_i] <= wt_data_i;
            end
            if (drain) begin
                res_mem_q[idx_q] <= store_val;
            end
        end

        assign ch_rd[g] = (32'(res_addr_i) < 32'(RES_DEPTH)) ? res_mem_q[res_addr_i] : '0;
    end

    assign res_data_o = (32'(res_ch_i) < 32'(NUM_CH)) ? ch_rd[res_ch_i] : '0;

endmodule

`default_nettype wire

// File: tb/tb_systolic_conv_engine.sv
// ============================================================================
// Module      : tb_systolic_conv_engine
// Description : Self-checking bench for systolic_conv_engine; results are
//               compared against a direct nested-loop convolution model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_conv_engine;

    localparam int NUM_CH    = 6;
    localparam int RES_DEPTH = 576;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  cfg_img_w_i, cfg_img_h_i;
    logic [3:0]  cfg_kernel_r_i;
    logic        start_i;
    logic        busy_o, done_o;
    logic [9:0]  rom_addr_o;
    logic        rom_rd_en_o;
    logic [7:0]  rom_data_i;
    logic        wt_we_i;
    logic [2:0]  wt_ch_i;
    logic [4:0]  wt_idx_i;
    logic [7:0]  wt_data_i;
    logic [2:0]  res_ch_i;
    logic [9:0]  res_addr_i;
    logic [31:0] res_data_o;

    systolic_conv_engine dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_img_w_i    (cfg_img_w_i),
        .cfg_img_h_i    (cfg_img_h_i),
        .cfg_kernel_r_i (cfg_kernel_r_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rom_addr_o     (rom_addr_o),
        .rom_rd_en_o    (rom_rd_en_o),
        .rom_data_i     (rom_data_i),
        .wt_we_i        (wt_we_i),
        .wt_ch_i        (wt_ch_i),
        .wt_idx_i       (wt_idx_i),
        .wt_data_i      (wt_data_i),
        .res_ch_i       (res_ch_i),
        .res_addr_i     (res_addr_i),
        .res_data_o     (res_data_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] rom_mem [1024];
    always @(posedge clk_i) begin
        if (rom_rd_en_o) rom_data_i <= rom_mem[rom_addr_o];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wt_model  [NUM_CH][25];
    int mem_model [NUM_CH][RES_DEPTH];

    // Cycle-level observation of DUT handshakes.
    int   cyc = 0, busy_rise_cyc = 0, done_cyc = 0, start_cyc = 0, done_cnt = 0, rd_cnt = 0;
    logic busy_prev = 1'b0;
    int   addr_log [$];
    always @(negedge clk_i) begin
        cyc++;
        if (busy_o && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy_o;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rom_rd_en_o) begin
            rd_cnt++;
            if (addr_log.size() < 64) addr_log.push_back(int'(rom_addr_o));
        end
        if (start_i) start_cyc = cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic write_wt(input int ch, input int idx, input int val);
        tick(1);
        wt_we_i   = 1'b1;
        wt_ch_i   = 3'(ch);
        wt_idx_i  = 5'(idx);
        wt_data_i = 8'(val);
        tick(1);
        wt_we_i   = 1'b0;
        wt_model[ch][idx] = val;
    endtask

    task automatic start_run(input int w, input int h, input int k);
        tick(1);
        cfg_img_w_i    = 8'(w);
        cfg_img_h_i    = 8'(h);
        cfg_kernel_r_i = 4'(k);
        start_i        = 1'b1;
        tick(1);
        start_i        = 1'b0;
        cfg_img_w_i    = 8'($urandom);
        cfg_img_h_i    = 8'($urandom);
        cfg_kernel_r_i = 4'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick(1);
        check_eq(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic model_run(input int w, input int h, input int k);
        int ow, oh, s;
        ow = w - k + 1;
        oh = h - k + 1;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int r = 0; r < oh; r++)
                for (int c = 0; c < ow; c++) begin
                    s = 0;
                    for (int kr = 0; kr < k; kr++)
                        for (int kc = 0; kc < k; kc++)
                            s += int'(rom_mem[(r + kr) * w + c + kc]) * wt_model[ch][kr * k + kc];
`ifdef CONV_ENGINE_RELU_EN
                    if (s < 0) s = 0;
`endif
                    mem_model[ch][r * ow + c] = s;
                end
    endtask

    task automatic read_res(input int ch, input int a, output logic [31:0] d);
        res_ch_i   = 3'(ch);
        res_addr_i = 10'(a);
        #1;
        d = res_data_o;
    endtask

    task automatic check_results(input string tag, input int n);
        logic [31:0] d;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int i = 0; i < n; i++) begin
                read_res(ch, i, d);
                check_eq($sformatf("%s[%0d][%0d]", tag, ch, i), d, 32'(mem_model[ch][i]));
            end
    endtask

    task automatic load_weights(input int kk, input bit rnd);
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int t = 0; t < kk; t++)
                write_wt(ch, t, rnd ? int'($urandom_range(0, 255)) - 128 : 0);
    endtask

    task automatic full_run(input string tag, input int w, input int h, input int k);
        int n;
        n = (w - k + 1) * (h - k + 1);
        model_run(w, h, k);
        start_run(w, h, k);
        wait_done({tag, "_done"}, n * (k * k + 1) + 20);
        check_eq({tag, "_cycles"}, 32'(done_cyc - busy_rise_cyc), 32'(n * (k * k + 1)));
        check_results(tag, n);
    endtask

    initial begin
        int          exp_addr [9];
        int          w, h, k, d0, r0;
        logic [31:0] d;

        rst_i = 1'b1; start_i = 1'b0; wt_we_i = 1'b0;
        cfg_img_w_i = 8'd0; cfg_img_h_i = 8'd0; cfg_kernel_r_i = 4'd0;
        wt_ch_i = 3'd0; wt_idx_i = 5'd0; wt_data_i = 8'd0;
        res_ch_i = 3'd0; res_addr_i = 10'd0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'd0;

        // Reset
        tick(3);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_rd_en", 32'(rom_rd_en_o), 32'd0);
        check_eq("rst_addr", 32'(rom_addr_o), 32'd0);
        rst_i = 1'b0;
        tick(2);

        // Address/order: 4x4 ramp image, centre tap of ch0 only
        for (int a = 0; a < 16; a++) rom_mem[a] = 8'(a);
        load_weights(9, 1'b0);
        write_wt(0, 4, 1);
        addr_log.delete();
        full_run("order", 4, 4, 3);
        exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("order_addr%0d", i), 32'(addr_log[i]), 32'(exp_addr[i]));
        read_res(0, 3, d);
        check_eq("order_res3", d, 32'd10);

        // Extremes: 1x1 image, 1x1 kernel
        rom_mem[0] = 8'd255;
        load_weights(1, 1'b0);
        write_wt(0, 0, -128);
        full_run("extreme", 1, 1, 1);
        read_res(0, 0, d);
`ifdef CONV_ENGINE_RELU_EN
        check_eq("extreme_val", d, 32'd0);
`else
        check_eq("extreme_val", d, 32'hFFFF_8080);
`endif

        // Full LeNet run
        for (int a = 0; a < 784; a++) rom_mem[a] = 8'd1;
        load_weights(25, 1'b0);
        for (int t = 0; t < 25; t++) begin
            write_wt(0, t, 1);
            write_wt(5, t, -2);
        end
        full_run("lenet", 28, 28, 5);
        check_eq("lenet_cycles_abs", 32'(done_cyc - busy_rise_cyc), 32'd14976);
        read_res(0, 575, d);
        check_eq("lenet_ch0_last", d, 32'd25);
        read_res(5, 0, d);
`ifdef CONV_ENGINE_RELU_EN
        check_eq("lenet_ch5_first", d, 32'd0);
`else
        check_eq("lenet_ch5_first", d, 32'hFFFF_FFCE);
`endif

        // Randomized shapes, pixels and weights
        for (int it = 0; it < 4; it++) begin
            k = int'($urandom_range(1, 5));
            w = int'($urandom_range(k, 12));
            h = int'($urandom_range(k, 12));
            for (int a = 0; a < w * h; a++) rom_mem[a] = 8'($urandom);
            load_weights(k * k, 1'b1);
            full_run($sformatf("rand%0d", it), w, h, k);
        end

        // Invalid configs: no reads, immediate done, memory untouched
        r0 = rd_cnt;
        start_run(28, 28, 0);
        wait_done("k0_done", 10);
        check_eq("k0_latency", 32'(done_cyc - start_cyc), 32'd1);
        start_run(28, 28, 6);
        wait_done("k6_done", 10);
        check_eq("k6_latency", 32'(done_cyc - start_cyc), 32'd1);
        start_run(3, 8, 4);
        wait_done("kw_done", 10);
        check_eq("invalid_no_reads", 32'(rd_cnt - r0), 32'd0);
        check_results("unchanged", (w - k + 1) * (h - k + 1));

        // Start pulse while busy is ignored
        for (int a = 0; a < 36; a++) rom_mem[a] = 8'($urandom);
        load_weights(9, 1'b1);
        model_run(6, 6, 3);
        d0 = done_cnt;
        start_run(6, 6, 3);
        tick(30);
        cfg_img_w_i = 8'd4; cfg_img_h_i = 8'd4; cfg_kernel_r_i = 4'd2;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(400);
        check_eq("restart_single_done", 32'(done_cnt - d0), 32'd1);
        check_eq("restart_cycles", 32'(done_cyc - busy_rise_cyc), 32'd160);
        check_results("restart", 16);

        // Reset mid-run aborts without done
        start_run(6, 6, 3);
        tick(20);
        check_eq("midrst_busy_before", 32'(busy_o), 32'd1);
        d0 = done_cnt;
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_rd_en", 32'(rom_rd_en_o), 32'd0);
        tick(200);
        check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
